// File: rtl/rtc_pkg.sv
// Shared definitions for the PRAM/RTC serial bus master.
// Command encodings and the transaction state machine encoding.
package rtc_pkg;

    localparam logic [7:0] RTC_RD_SEC0 = 8'h81;
    localparam logic [7:0] RTC_WR_SEC0 = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CK_HI,
        ST_CK_LO,
        ST_HOLD,
        ST_DONE,
        ST_GAP
    } rtc_state_t;

    // Read of PRAM byte a: read flag, RAM select, address, marker bit.
    function automatic logic [7:0] rtc_rd_ram(input logic [3:0] a);
        return 8'hC1 | {2'b00, a, 2'b00};
    endfunction

    // Write of PRAM byte a.
    function automatic logic [7:0] rtc_wr_ram(input logic [3:0] a);
        return 8'h41 | {2'b00, a, 2'b00};
    endfunction

endpackage

// File: rtl/rtc_serial_master_tick.sv
// Reloadable down-counter for the serial master.
// expire is high once the loaded count has run down to zero.
module rtc_ser_tick #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;

    // Reload on state entry, otherwise count down and stick at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/rtc_serial_master.sv
// Three-wire PRAM/RTC serial bus master: one command byte then
// one write byte or one captured read byte per request.
module rtc_serial_master
    import rtc_pkg::*;
#(
    parameter int HALF = 16,
    parameter int GAP  = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_cmd,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       cs_n,
    output logic       ck,
    output logic       dat_o,
    input  logic       dat_i
);

    localparam int MAXC = (HALF > GAP) ? HALF : GAP;
    localparam int CW   = $clog2(MAXC);
    localparam logic [CW-1:0] HALF_LD = CW'(HALF - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP - 1);

    rtc_state_t    state;
    logic [15:0]   shreg;
    logic          rd;
    logic [3:0]    bitcnt;
    logic [7:0]    rdreg;
    logic          load;
    logic [CW-1:0] load_val;
    logic          expire;

    rtc_ser_tick #(.W(CW)) u_tick (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .load_val (load_val),
        .expire   (expire)
    );

    // Reload the tick counter on every state change.
    always_comb begin
        load     = 1'b0;
        load_val = HALF_LD;
        unique case (state)
            ST_IDLE: load = req_valid;
            ST_DONE: begin
                load     = 1'b1;
                load_val = GAP_LD;
            end
            default: load = expire;
        endcase
    end

    // Transaction sequencer with registered bus and handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            rd        <= 1'b0;
            bitcnt    <= '0;
            rdreg     <= '0;
            cs_n      <= 1'b1;
            ck        <= 1'b0;
            dat_o     <= 1'b1;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        shreg     <= {req_cmd, req_wdata};
                        rd        <= req_cmd[7];
                        bitcnt    <= '0;
                        rdreg     <= '0;
                        req_ready <= 1'b0;
                        cs_n      <= 1'b0;
                        ck        <= 1'b0;
                        dat_o     <= req_cmd[7];
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    dat_o <= shreg[15];
                    if (expire) begin
                        ck    <= 1'b1;
                        state <= ST_CK_HI;
                    end
                end
                ST_CK_HI: begin
                    if (expire) begin
                        ck     <= 1'b0;
                        shreg  <= {shreg[14:0], 1'b1};
                        dat_o  <= (rd && bitcnt >= 4'd7) ? 1'b1 : shreg[14];
                        bitcnt <= bitcnt + 4'd1;
                        state  <= ST_CK_LO;
                    end
                end
                ST_CK_LO: begin
                    if (expire) begin
                        // bitcnt wraps to zero after the 16th bit
                        if (bitcnt == 4'd0) begin
                            state <= ST_HOLD;
                        end else begin
                            ck    <= 1'b1;
                            state <= ST_CK_HI;
                            if (rd && bitcnt[3]) begin
                                rdreg <= {rdreg[6:0], dat_i};
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (expire) begin
                        cs_n      <= 1'b1;
                        dat_o     <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rd ? rdreg : 8'h00;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_GAP;
                end
                ST_GAP: begin
                    if (expire) begin
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = ~req_ready;

endmodule

// File: tb/tb_rtc_serial_master.sv
// Bench for rtc_serial_master with a behavioural RTC/PRAM slave.
// Instance 0 runs HALF=16, instance 1 runs HALF=4.
module tb_rtc_serial_master;

    localparam int H0 = 16;
    localparam int H1 = 4;
    localparam int GP = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [1:0] req_valid, req_ready, rsp_valid, busy;
    logic [1:0] cs_n, ck, dat_o, dat_i;
    logic [7:0] req_cmd [2];
    logic [7:0] req_wdata [2];
    logic [7:0] rsp_rdata [2];

    int n_vec = 0;
    int n_err = 0;

    rtc_serial_master #(.HALF(H0), .GAP(GP)) u0 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_cmd(req_cmd[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .busy(busy[0]), .cs_n(cs_n[0]), .ck(ck[0]),
        .dat_o(dat_o[0]), .dat_i(dat_i[0])
    );

    rtc_serial_master #(.HALF(H1), .GAP(GP)) u1 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_cmd(req_cmd[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .busy(busy[1]), .cs_n(cs_n[1]), .ck(ck[1]),
        .dat_o(dat_o[1]), .dat_i(dat_i[1])
    );

    // Slave model: samples on ck rise, shifts out after ck fall.
    logic [1:0] s_ckq;
    logic [4:0] s_cnt [2];
    logic [6:0] s_sh [2];
    logic [7:0] s_cmd [2];
    logic [7:0] s_out [2];
    logic [7:0] s_sec [2];
    logic [7:0] s_mem [2][16];

    function automatic logic [7:0] peek(input int k, input logic [7:0] c);
        return c[6] ? s_mem[k][c[5:2]] : s_sec[k];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                s_ckq[k] <= 1'b0;
                s_cnt[k] <= '0;
                s_sh[k]  <= '0;
                s_cmd[k] <= '0;
                s_out[k] <= '0;
                s_sec[k] <= '0;
                dat_i[k] <= 1'b1;
                for (int i = 0; i < 16; i++)
                    s_mem[k][i] <= 8'hA8 ^ 8'(i * 17);
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                s_ckq[k] <= ck[k];
                if (cs_n[k]) begin
                    s_cnt[k] <= '0;
                    dat_i[k] <= 1'b1;
                end else begin
                    if (ck[k] && !s_ckq[k]) begin
                        s_sh[k]  <= {s_sh[k][5:0], dat_o[k]};
                        s_cnt[k] <= s_cnt[k] + 5'd1;
                        if (s_cnt[k] == 5'd7) begin
                            s_cmd[k] <= {s_sh[k], dat_o[k]};
                            s_out[k] <= peek(k, {s_sh[k], dat_o[k]});
                        end
                        if (s_cnt[k] == 5'd15 && !s_cmd[k][7]) begin
                            if (s_cmd[k][6])
                                s_mem[k][s_cmd[k][5:2]] <= {s_sh[k], dat_o[k]};
                            else
                                s_sec[k] <= {s_sh[k], dat_o[k]};
                        end
                    end
                    if (!ck[k] && s_ckq[k] && s_cnt[k] >= 5'd8 && s_cmd[k][7]) begin
                        dat_i[k] <= s_out[k][7];
                        s_out[k] <= {s_out[k][6:0], 1'b0};
                    end
                end
            end
        end
    end

    // Bus monitor: ck rises, cs_n falls, length of last cs_n-high run.
    int rises [2];
    int falls [2];
    int hi_run [2];
    int last_gap [2];
    logic [1:0] m_ckq, m_csq;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_ckq[k] <= ck[k];
            m_csq[k] <= cs_n[k];
            if (ck[k] === 1'b1 && m_ckq[k] === 1'b0)
                rises[k] <= rises[k] + 1;
            if (cs_n[k] === 1'b0 && m_csq[k] === 1'b1)
                falls[k] <= falls[k] + 1;
            if (cs_n[k]) begin
                hi_run[k] <= hi_run[k] + 1;
            end else begin
                if (hi_run[k] != 0) last_gap[k] <= hi_run[k];
                hi_run[k] <= 0;
            end
        end
    end

    task automatic start(input int k, input logic [7:0] c,
                         input logic [7:0] w, output bit ok);
        int t;
        t = 0;
        ok = 1'b1;
        while (req_ready[k] !== 1'b1 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (req_ready[k] !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL start_timeout inst%0d: req_ready=%b want 1", k, req_ready[k]);
            ok = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_cmd[k]   = c;
        req_wdata[k] = w;
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        req_cmd[k]   = 8'($urandom);
        req_wdata[k] = 8'($urandom);
    endtask

    task automatic wait_rsp(input int k, output int lat, output bit to);
        lat = 0;
        to  = 1'b1;
        while (lat < 4000) begin
            @(posedge clk); #1;
            lat++;
            if (rsp_valid[k] === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic txn(input int k, input logic [7:0] c, input logic [7:0] w,
                       output logic [7:0] rd, output int lat);
        bit ok, to;
        rd  = 8'hxx;
        lat = 0;
        start(k, c, w, ok);
        if (!ok) return;
        wait_rsp(k, lat, to);
        if (to) begin
            n_vec++; n_err++;
            $display("FAIL rsp_timeout inst%0d cmd %h: no rsp_valid", k, c);
        end
        rd = rsp_rdata[k];
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if ({cs_n[k], ck[k], dat_o[k]} !== 3'b101) begin
                n_err++;
                $display("FAIL reset_bus inst%0d: cs_n/ck/dat_o=%b want 101",
                         k, {cs_n[k], ck[k], dat_o[k]});
            end
            n_vec++;
            if ({req_ready[k], busy[k], rsp_valid[k]} !== 3'b100) begin
                n_err++;
                $display("FAIL reset_hs inst%0d: ready/busy/rsp_valid=%b want 100",
                         k, {req_ready[k], busy[k], rsp_valid[k]});
            end
            n_vec++;
            if (rsp_rdata[k] !== 8'h00) begin
                n_err++;
                $display("FAIL reset_rdata inst%0d: %h want 00", k, rsp_rdata[k]);
            end
        end
    endtask

    task automatic test_read_default();
        int r0, lat;
        bit ok, to;
        r0 = rises[0];
        start(0, 8'hC1, 8'h00, ok);
        if (!ok) return;
        n_vec++;
        if ({cs_n[0], busy[0]} !== 2'b01) begin
            n_err++;
            $display("FAIL accept_cs inst0: cs_n/busy=%b want 01", {cs_n[0], busy[0]});
        end
        wait_rsp(0, lat, to);
        n_vec++;
        if (to || lat + 1 != 34 * H0 + 1) begin
            n_err++;
            $display("FAIL latency_h16: %0d cycles want %0d", lat + 1, 34 * H0 + 1);
        end
        n_vec++;
        if (rsp_rdata[0] !== 8'hA8) begin
            n_err++;
            $display("FAIL read_default: rdata %h want a8", rsp_rdata[0]);
        end
        n_vec++;
        if (rises[0] - r0 != 16) begin
            n_err++;
            $display("FAIL ck_rises: %0d want 16", rises[0] - r0);
        end
    endtask

    task automatic test_write_read();
        logic [7:0] rd;
        int lat;
        txn(0, 8'h41, 8'h5A, rd, lat);
        n_vec++;
        if (rd !== 8'h00) begin
            n_err++;
            $display("FAIL write_rdata: %h want 00", rd);
        end
        txn(0, 8'hC1, 8'h00, rd, lat);
        n_vec++;
        if (rd !== 8'h5A) begin
            n_err++;
            $display("FAIL readback_ram0: %h want 5a", rd);
        end
    endtask

    task automatic test_seconds();
        logic [7:0] rd;
        int lat;
        txn(0, 8'h01, 8'h3C, rd, lat);
        n_vec++;
        if (rd !== 8'h00) begin
            n_err++;
            $display("FAIL sec_write_rdata: %h want 00", rd);
        end
        txn(0, 8'h81, 8'h00, rd, lat);
        n_vec++;
        if (rd !== 8'h3C && rd !== 8'h3D) begin
            n_err++;
            $display("FAIL sec_read: %h want 3c or 3d", rd);
        end
    endtask

    task automatic test_busy();
        int f0, lat, n;
        bit ok, to, ready_bad;
        f0 = falls[0];
        start(0, 8'hC1, 8'h00, ok);
        if (!ok) return;
        lat = 0;
        to = 1'b1;
        ready_bad = 1'b0;
        while (lat < 4000) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 100) begin
                req_valid[0] = 1'b1;
                req_cmd[0]   = 8'h45;
                req_wdata[0] = 8'hFF;
            end else if (lat == 101) begin
                req_valid[0] = 1'b0;
            end
            if (rsp_valid[0] === 1'b1) begin
                to = 1'b0;
                break;
            end
            if (req_ready[0] !== 1'b0) ready_bad = 1'b1;
        end
        n_vec++;
        if (to || ready_bad) begin
            n_err++;
            $display("FAIL busy_ready: timeout=%b ready_seen=%b want 0 0", to, ready_bad);
        end
        n_vec++;
        if (rsp_rdata[0] !== 8'h5A) begin
            n_err++;
            $display("FAIL busy_rdata: %h want 5a", rsp_rdata[0]);
        end
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        n_vec++;
        if (n != GP + 1) begin
            n_err++;
            $display("FAIL rsp_to_ready: %0d cycles want %0d", n, GP + 1);
        end
        repeat (20) @(posedge clk);
        #1;
        n_vec++;
        if (falls[0] - f0 != 1) begin
            n_err++;
            $display("FAIL busy_ignored: %0d cs_n falls want 1", falls[0] - f0);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit ok, early;
        logic [7:0] rd;
        start(0, 8'hC1, 8'h00, ok);
        if (!ok) return;
        lat = 0;
        early = 1'b0;
        while (lat < 21 * H0 + 3) begin
            @(posedge clk); #1;
            lat++;
            if (rsp_valid[0] !== 1'b0) early = 1'b1;
        end
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({cs_n[0], ck[0], dat_o[0]} !== 3'b101) begin
            n_err++;
            $display("FAIL abort_bus: cs_n/ck/dat_o=%b want 101",
                     {cs_n[0], ck[0], dat_o[0]});
        end
        repeat (3) begin
            @(posedge clk); #1;
            if (rsp_valid[0] !== 1'b0) early = 1'b1;
        end
        n_vec++;
        if (early || req_ready[0] !== 1'b1) begin
            n_err++;
            $display("FAIL abort_rsp: rsp_seen=%b ready=%b want 0 1", early, req_ready[0]);
        end
        @(negedge clk);
        reset_n = 1'b1;
        txn(0, 8'hC1, 8'h00, rd, lat);
        n_vec++;
        if (rd !== 8'hA8) begin
            n_err++;
            $display("FAIL after_abort: rdata %h want a8", rd);
        end
    endtask

    task automatic test_min_half();
        logic [7:0] cv [5] = '{8'hC1, 8'hCD, 8'h45, 8'hC5, 8'hC1};
        logic [7:0] wv [5] = '{8'h00, 8'h00, 8'hC3, 8'h00, 8'h00};
        logic [7:0] ev [5] = '{8'hA8, 8'h9B, 8'h00, 8'hC3, 8'hA8};
        logic [7:0] rd;
        int lat, r0;
        for (int i = 0; i < 5; i++) begin
            r0 = rises[1];
            txn(1, cv[i], wv[i], rd, lat);
            n_vec++;
            if (rd !== ev[i]) begin
                n_err++;
                $display("FAIL h4_data[%0d]: %h want %h", i, rd, ev[i]);
            end
            n_vec++;
            if (lat + 1 != 34 * H1 + 1 || rises[1] - r0 != 16) begin
                n_err++;
                $display("FAIL h4_timing[%0d]: %0d cycles %0d rises want %0d 16",
                         i, lat + 1, rises[1] - r0, 34 * H1 + 1);
            end
            if (i > 0) begin
                n_vec++;
                if (last_gap[1] < GP) begin
                    n_err++;
                    $display("FAIL h4_gap[%0d]: cs_n high %0d want >= %0d",
                             i, last_gap[1], GP);
                end
            end
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        req_valid    = '0;
        req_cmd[0]   = '0;
        req_cmd[1]   = '0;
        req_wdata[0] = '0;
        req_wdata[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset_n = 1'b1;
        test_read_default();
        test_write_read();
        test_seconds();
        test_busy();
        test_reset_mid();
        test_min_half();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
